// File: rtl/bcd_tick_counter.sv
// bcd_tick_counter: synchronizes the divider's slow square wave into clk_in,
// detects its rising edges and uses them to step a DIGITS-wide BCD counter
// under start/stop/clear control, pulsing wrap on roll-over.
// Optional feature macro: BCD_DOWN_EN adds the dir port and down counting.
//
// state | meaning
// IDLE  | stopped at zero after reset or clear, waiting for start
// RUN   | counting one step per detected tick edge
// PAUSE | count frozen, resumes on start
module bcd_tick_counter #(
  parameter int DIGITS      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk_in,
  input  logic                rst_n,
  input  logic                tick_in,
  input  logic                start,
  input  logic                stop,
  input  logic                clear,
`ifdef BCD_DOWN_EN
  input  logic                dir,
`endif
  output logic [4*DIGITS-1:0] count,
  output logic                running,
  output logic                tick_seen,
  output logic                wrap
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic                   tick_edge;
  logic                   count_down;
  logic [4*DIGITS-1:0]    count_next;
  logic                   carry;

`ifdef BCD_DOWN_EN
  assign count_down = dir;
`else
  assign count_down = 1'b0;
`endif

  // Synchronizer chain plus one history flop for rising-edge detection
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], tick_in};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign tick_edge = sync[SYNC_STAGES-1] & ~prev;

  // Ripple BCD step; carry out of the top digit marks a wrap
  always_comb begin
    count_next = count;
    carry      = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (count_down) begin
          if (count[4*i +: 4] == 4'd0) begin
            count_next[4*i +: 4] = 4'd9;
          end else begin
            count_next[4*i +: 4] = count[4*i +: 4] - 4'd1;
            carry                = 1'b0;
          end
        end else begin
          if (count[4*i +: 4] >= 4'd9) begin
            count_next[4*i +: 4] = 4'd0;
          end else begin
            count_next[4*i +: 4] = count[4*i +: 4] + 4'd1;
            carry                = 1'b0;
          end
        end
      end
    end
  end

  // Control FSM with registered count, running and wrap
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      count   <= '0;
      running <= 1'b0;
      wrap    <= 1'b0;
    end else if (clear) begin
      state   <= IDLE;
      count   <= '0;
      running <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      wrap <= 1'b0;
      // A tick in the same cycle as stop still counts; the pause follows
      if (tick_edge && state == RUN) begin
        count <= count_next;
        wrap  <= carry;
      end
      case (state)
        RUN: begin
          if (stop) begin
            state   <= PAUSE;
            running <= 1'b0;
          end
        end
        IDLE, PAUSE: begin
          if (start) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

  // Edge pulse reported in every state, independent of clear
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      tick_seen <= 1'b0;
    end else begin
      tick_seen <= tick_edge;
    end
  end

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Testbench for bcd_tick_counter: directed and random tick/control stimulus
// compared every cycle against a decimal-value reference model.
// Down-count checks are compiled in when BCD_DOWN_EN is defined.
module tb_bcd_tick_counter;
  localparam int DIGITS = 4;
  localparam int SYNC   = 2;
  localparam int MODV   = 10000;

  logic        clk_in = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick_in = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        clear = 1'b0;
`ifdef BCD_DOWN_EN
  logic        dir = 1'b0;
`endif
  logic [15:0] count;
  logic        running;
  logic        tick_seen;
  logic        wrap;

  bcd_tick_counter #(.DIGITS(DIGITS), .SYNC_STAGES(SYNC)) dut (
    .clk_in(clk_in),
    .rst_n(rst_n),
    .tick_in(tick_in),
    .start(start),
    .stop(stop),
    .clear(clear),
`ifdef BCD_DOWN_EN
    .dir(dir),
`endif
    .count(count),
    .running(running),
    .tick_seen(tick_seen),
    .wrap(wrap)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: decimal value, state as 0 idle / 1 run / 2 pause
  int nvec = 0;
  int nerr = 0;
  int m_val = 0;
  int m_state = 0;
  bit m_tick = 0;
  bit m_wrap = 0;
  bit samp[$];

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    samp.delete();
    m_val   = 0;
    m_state = 0;
    m_tick  = 0;
    m_wrap  = 0;
  endtask

  task automatic model_clock();
    int  n;
    bit  e;
    bit  down;
    down = 0;
`ifdef BCD_DOWN_EN
    down = dir;
`endif
    samp.push_back(tick_in);
    if (samp.size() > SYNC + 2) void'(samp.pop_front());
    n = samp.size();
    // edge seen SYNC samples after tick_in first sampled high
    e = (n >= SYNC + 1) && samp[n-1-SYNC] && !((n >= SYNC + 2) ? samp[n-2-SYNC] : 1'b0);
    m_tick = e;
    m_wrap = 0;
    if (clear) begin
      m_val   = 0;
      m_state = 0;
    end else begin
      if (e && m_state == 1) begin
        if (down) begin
          m_wrap = (m_val == 0);
          m_val  = (m_val + MODV - 1) % MODV;
        end else begin
          m_wrap = (m_val == MODV - 1);
          m_val  = (m_val + 1) % MODV;
        end
      end
      if (m_state == 1 && stop) m_state = 2;
      else if (m_state != 1 && start) m_state = 1;
    end
  endtask

  task automatic check_all();
    nvec++;
    assert (count === to_bcd(m_val)) else begin
      nerr++;
      $error("FAIL count: got %h want %h at %0t", count, to_bcd(m_val), $time);
    end
    nvec++;
    assert (running === (m_state == 1)) else begin
      nerr++;
      $error("FAIL running: got %b want %b at %0t", running, (m_state == 1), $time);
    end
    nvec++;
    assert (tick_seen === m_tick) else begin
      nerr++;
      $error("FAIL tick_seen: got %b want %b at %0t", tick_seen, m_tick, $time);
    end
    nvec++;
    assert (wrap === m_wrap) else begin
      nerr++;
      $error("FAIL wrap: got %b want %b at %0t", wrap, m_wrap, $time);
    end
  endtask

  task automatic check_count(input string tag, input logic [15:0] want);
    nvec++;
    assert (count === want) else begin
      nerr++;
      $error("FAIL %s: got %h want %h", tag, count, want);
    end
  endtask

  task automatic check_bit(input string tag, input logic got, input logic want);
    nvec++;
    assert (got === want) else begin
      nerr++;
      $error("FAIL %s: got %b want %b", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    model_clock();
    #1;
    check_all();
  endtask

  // One tick_in period; ctl 1 = stop, 2 = clear on the edge that updates count
  task automatic tick(input int hi, input int lo, input int ctl);
    for (int i = 0; i < hi; i++) begin
      tick_in = 1'b1;
      if (i == SYNC) begin
        stop  = (ctl == 1);
        clear = (ctl == 2);
      end
      step();
      stop  = 1'b0;
      clear = 1'b0;
    end
    for (int i = 0; i < lo; i++) begin
      tick_in = 1'b0;
      step();
    end
  endtask

  task automatic fast_ticks(input int n);
    for (int i = 0; i < n; i++) tick(SYNC + 1, SYNC + 1, 0);
  endtask

  task automatic pulse(input int which);
    start = (which == 0);
    stop  = (which == 1);
    clear = (which == 2);
    step();
    start = 1'b0;
    stop  = 1'b0;
    clear = 1'b0;
  endtask

  initial begin
    // Reset held while tick_in toggles: all outputs stay zero
    for (int i = 0; i < 8; i++) begin
      tick_in = i[1];
      @(posedge clk_in);
      #1;
    end
    check_count("rst_count", 16'h0000);
    check_bit("rst_running", running, 1'b0);
    check_bit("rst_tick_seen", tick_seen, 1'b0);
    check_bit("rst_wrap", wrap, 1'b0);

    // Release with tick_in high: one edge reported, nothing counted
    model_reset();
    tick_in = 1'b1;
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
    tick_in = 1'b0;
    for (int i = 0; i < 4; i++) step();
    for (int i = 0; i < 3; i++) tick($urandom_range(3, 6), $urandom_range(3, 6), 0);
    check_count("idle_no_count", 16'h0000);

    // start, then 12 ticks
    pulse(0);
    for (int i = 0; i < 12; i++) tick($urandom_range(3, 7), $urandom_range(3, 7), 0);
    check_count("count_12", 16'h0012);

    // Carry across digits, then full wrap
    fast_ticks(987);
    check_count("count_0999", 16'h0999);
    fast_ticks(1);
    check_count("count_1000", 16'h1000);
    fast_ticks(8999);
    check_count("count_9999", 16'h9999);
    fast_ticks(1);
    check_count("wrap_0000", 16'h0000);

    // stop coincident with a tick still counts it, then pause
    fast_ticks(5);
    check_count("count_0005", 16'h0005);
    tick(3, 3, 1);
    check_count("stop_edge", 16'h0006);
    check_bit("paused", running, 1'b0);
    fast_ticks(3);
    check_count("pause_hold", 16'h0006);
    pulse(0);
    fast_ticks(1);
    check_count("resume", 16'h0007);

    // clear coincident with a tick wins
    fast_ticks(35);
    check_count("count_0042", 16'h0042);
    tick(3, 3, 2);
    check_count("clear_edge", 16'h0000);
    check_bit("clear_idle", running, 1'b0);

    // Asynchronous reset mid-run
    pulse(0);
    fast_ticks(123);
    check_count("count_0123", 16'h0123);
    #2 rst_n = 1'b0;
    #1;
    check_count("async_rst_count", 16'h0000);
    check_bit("async_rst_running", running, 1'b0);
    model_reset();
    tick_in = 1'b0;
    @(posedge clk_in);
    #2 rst_n = 1'b1;
    step();

`ifdef BCD_DOWN_EN
    pulse(0);
    dir = 1'b1;
    step();
    fast_ticks(1);
    check_count("down_wrap", 16'h9999);
    pulse(2);
    pulse(0);
    dir = 1'b0;
    fast_ticks(100);
    check_count("count_0100", 16'h0100);
    dir = 1'b1;
    fast_ticks(1);
    check_count("down_0099", 16'h0099);
    for (int i = 0; i < 6; i++) begin
      dir = ~dir;
      step();
    end
    check_count("dir_toggle_hold", 16'h0099);
`endif

    // Random mix of ticks and control pulses
    for (int i = 0; i < 400; i++) begin
      int r;
`ifdef BCD_DOWN_EN
      dir = 1'($urandom_range(0, 1));
`endif
      r = $urandom_range(0, 9);
      if (r < 6) tick($urandom_range(3, 6), $urandom_range(3, 6),
                      ($urandom_range(0, 7) < 2) ? $urandom_range(1, 2) : 0);
      else if (r == 6) pulse(0);
      else if (r == 7) pulse(1);
      else if (r == 8) pulse(($urandom_range(0, 3) == 0) ? 2 : 0);
      else step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
